// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arm_fetch_pkg;
  localparam int          WORD_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  T              w_zero;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_zero  = '0;
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  // A pop frees the slot, so push on a full FIFO is accepted when it pops too.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? w_zero : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with an in-order prefetch queue and redirect/flush.
module fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outst, r_drop;
  logic          r_live;

  logic [CW-1:0] w_q_cnt, w_tag_cnt;
  logic          w_q_full, w_q_empty, w_tag_full, w_tag_empty;
  logic [CW:0]   w_occ;
  logic          w_fire, w_keep, w_pop;
  logic [31:0]   w_tag_pc;
  fetch_entry_t  w_head, w_push_ent;

  // Queued plus in-flight words are capped so every response has a slot.
  assign w_occ          = {1'b0, w_q_cnt} + {1'b0, r_outst};
  assign imem_req_valid = r_live && !redirect && (w_occ < (CW+1)'(DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign w_keep         = imem_rsp_valid && (r_drop == '0) && !redirect;
  assign w_push_ent     = '{pc: w_tag_pc, instr: imem_rsp_data};

  assign instr_valid = !w_q_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign w_pop       = instr_valid && instr_ready;

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_iq (
    .clk(clk), .rst_n(reset), .i_flush(redirect), .i_push(w_keep), .i_data(w_push_ent),
    .i_pop(w_pop), .o_head(w_head), .o_count(w_q_cnt), .o_full(w_q_full), .o_empty(w_q_empty)
  );

  // Tags are never flushed: stale responses still need their entry popped.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [WORD_W-1:0])) u_tag (
    .clk(clk), .rst_n(reset), .i_flush(1'b0), .i_push(w_fire), .i_data(r_fetch_pc),
    .i_pop(imem_rsp_valid), .o_head(w_tag_pc), .o_count(w_tag_cnt), .o_full(w_tag_full),
    .o_empty(w_tag_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= redirect_target & ~32'h3;
        r_outst    <= r_outst - CW'(imem_rsp_valid);
        r_drop     <= r_outst - CW'(imem_rsp_valid);
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + PC_INC;
        r_outst <= r_outst + CW'(w_fire) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
    end
  end

  a_occ:     assert property (@(posedge clk) disable iff (!reset) w_occ <= (CW+1)'(DEPTH));
  a_rsp:     assert property (@(posedge clk) disable iff (!reset) !(imem_rsp_valid && w_tag_empty));
  a_tag:     assert property (@(posedge clk) disable iff (!reset) w_tag_cnt == r_outst);
  a_tagfull: assert property (@(posedge clk) disable iff (!reset) !(w_fire && w_tag_full && !imem_rsp_valid));
  a_qfull:   assert property (@(posedge clk) disable iff (!reset) !(w_keep && w_q_full && !w_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-level reference model plus hand-computed checkpoints.
module tb_fetch_unit;
  logic clk;
  logic reset;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, redirect;
  logic [31:0] imem_addr, imem_rsp_data, instr, instr_pc, redirect_target;

  logic w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready, w_redirect;
  logic [31:0] w_addr, w_rsp_data, w_instr, w_instr_pc, w_target;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(w_instr_ready),
    .redirect(w_redirect), .redirect_target(w_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct packed { logic [31:0] pc; logic stale; } flight_t;
  typedef struct packed { logic [31:0] due; logic [31:0] addr; } mreq_t;

  int n_cmp = 0, n_bad = 0;
  ent_t        m_q[$];
  flight_t     m_fl[$];
  logic [31:0] m_pc;
  bit          m_live;
  mreq_t       mem_q[$];
  int          lat = 1;
  int          cyc = 0;
  int          req_cnt = 0;
  logic [31:0] cons_pc[$];
  logic        w_pend;
  logic [31:0] w_pend_addr;
  logic [31:0] w_pcs[$], w_dat[$];
  bit          w_done = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory responses, compare at negedge, advance model.
  task automatic tick();
    logic exp_rv, fire, pop, rsp;
    flight_t f;
    imem_rsp_valid = (mem_q.size() != 0) && (mem_q[0].due == cyc);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    w_rsp_valid    = w_pend;
    w_rsp_data     = mem_word(w_pend_addr);
    @(negedge clk);
    if (!reset) begin
      m_q.delete(); m_fl.delete(); m_pc = 32'h0; m_live = 0;
    end
    exp_rv = m_live && !redirect && (m_q.size() + m_fl.size() < 4);
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
    check("instr", instr, (m_q.size() != 0) ? m_q[0].data : 32'h0);
    check("instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
    rsp = imem_rsp_valid;
    if (rsp) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{due: 32'(cyc + lat), addr: imem_addr});
      req_cnt++;
    end
    if (instr_valid && instr_ready) cons_pc.push_back(instr_pc);
    if (reset) begin
      fire = exp_rv && imem_req_ready;
      pop  = (m_q.size() != 0) && instr_ready;
      if (pop) void'(m_q.pop_front());
      if (rsp) begin
        if (m_fl.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_order: response with no request in flight (cycle %0d)", cyc);
        end else begin
          f = m_fl.pop_front();
          if (!f.stale && !redirect) m_q.push_back('{pc: f.pc, data: mem_word(f.pc)});
        end
      end
      if (redirect) begin
        m_q.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_pc = redirect_target & ~32'h3;
      end else if (fire) begin
        m_fl.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_live = 1;
      if (!w_done && w_instr_valid) begin
        w_pcs.push_back(w_instr_pc);
        w_dat.push_back(w_instr);
        if (w_pcs.size() == 3) w_done = 1;
      end
    end
    w_pend      = w_req_valid && w_req_ready;
    w_pend_addr = w_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mem_q.delete();
    w_pend = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_addr_wrap", w_addr, 32'hFFFF_FFF8);
    reset = 1'b1;
    tick();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("first_req_addr", imem_addr, 32'h0);
    req_cnt = 0;
  endtask

  function automatic int count_below(input logic [31:0] lim);
    int n = 0;
    foreach (cons_pc[i]) if (cons_pc[i] < lim) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] rdy_pat, ir_pat;
    reset = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    redirect_target = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    w_req_ready = 1'b1; w_instr_ready = 1'b1; w_redirect = 1'b0; w_target = 32'h0;
    w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_pend = 1'b0; w_pend_addr = 32'h0;
    m_pc = 32'h0; m_live = 0;

    // Streaming, single-cycle memory
    lat = 1; apply_reset(); cons_pc.delete();
    for (int i = 0; i < 12; i++) tick();
    check("stream_count", cons_pc.size(), 32'd10);
    for (int i = 0; i < 10 && i < cons_pc.size(); i++) check("stream_pc", cons_pc[i], 32'(4 * i));

    // Backpressure: queue fills, requests stop at four
    lat = 1; instr_ready = 1'b0; apply_reset();
    for (int i = 0; i < 10; i++) tick();
    check("bp_req_cnt", req_cnt, 32'd4);
    check("bp_instr_valid", {31'b0, instr_valid}, 32'h1);
    check("bp_instr_pc", instr_pc, 32'h0);
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
    cons_pc.delete(); instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 8 && i < cons_pc.size(); i++) check("bp_resume_pc", cons_pc[i], 32'(4 * i));
    check("bp_resume_cnt_ge8", {31'b0, cons_pc.size() >= 8}, 32'h1);

    // Redirect with three requests in flight on a 3-cycle memory
    lat = 3; apply_reset();
    for (int i = 0; i < 3; i++) tick();
    redirect = 1'b1; redirect_target = 32'h100; #1;
    check("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    redirect = 1'b0; cons_pc.delete();
    check("redir_r1_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check("redir_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hX, 32'h100);
    check("redir_second_pc", (cons_pc.size() > 1) ? cons_pc[1] : 32'hX, 32'h104);
    check("redir_no_stale", count_below(32'h100), 32'd0);

    // Redirect coinciding with a response and a consume
    lat = 1; apply_reset();
    for (int i = 0; i < 5; i++) tick();
    redirect = 1'b1; redirect_target = 32'h203; #1;
    check("coinc_pre_valid", {31'b0, instr_valid}, 32'h1);
    tick();
    redirect = 1'b0; #1;
    check("coinc_r1_valid", {31'b0, instr_valid}, 32'h0);
    check("coinc_r1_addr", imem_addr, 32'h200);
    check("coinc_r1_req", {31'b0, imem_req_valid}, 32'h1);
    cons_pc.delete();
    for (int i = 0; i < 6; i++) tick();
    check("coinc_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hX, 32'h200);
    check("coinc_second_pc", (cons_pc.size() > 1) ? cons_pc[1] : 32'hX, 32'h204);

    // Back-to-back redirects under mixed backpressure
    lat = 2; apply_reset();
    rdy_pat = 32'b1011_0111_1101_1110_1110_1101_0111_1011;
    ir_pat  = 32'b0110_1101_1011_0111_1100_1110_1011_1101;
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = rdy_pat[i]; instr_ready = ir_pat[i]; tick();
    end
    redirect = 1'b1; redirect_target = 32'h300; tick();
    redirect_target = 32'h404; tick();
    redirect = 1'b0; cons_pc.delete();
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = rdy_pat[i % 32]; instr_ready = ir_pat[(i + 5) % 32]; tick();
    end
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("b2b_first_pc", (cons_pc.size() > 0) ? cons_pc[0] : 32'hX, 32'h404);
    check("b2b_no_old", count_below(32'h404), 32'd0);

    // Address wrap on the second instance
    check("wrap_seen", w_pcs.size(), 32'd3);
    if (w_pcs.size() == 3) begin
      check("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
      check("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
      check("wrap_pc2", w_pcs[2], 32'h0000_0000);
      check("wrap_data2", w_dat[2], mem_word(32'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
